// File: rtl/ram8_pkg.sv
// ram8_pkg: shared word and address sizing for ram8 and the larger RAMs tiled from it.
package ram8_pkg;
    localparam int WORD_WIDTH  = 16;
    localparam int RAM8_ADDR_W = 3;
    localparam int RAM8_DEPTH  = 1 << RAM8_ADDR_W;
endpackage

// File: rtl/ram8_demux8way.sv
// demux8way: routes one strobe to one of eight outputs; sel[2] at the root, sel[0] at the leaves.
module demux8way
    import ram8_pkg::*;
(
    input  logic                   i_in,
    input  logic [RAM8_ADDR_W-1:0] i_sel,
    output logic [RAM8_DEPTH-1:0]  o_y
);
    logic [1:0] w_l0;
    logic [3:0] w_l1;
    dmux2 u_root (.i_in(i_in), .i_sel(i_sel[2]), .o_a(w_l0[0]), .o_b(w_l0[1]));
    for (genvar k = 0; k < 2; k++) begin : g_l1
        dmux2 u_d (.i_in(w_l0[k]), .i_sel(i_sel[1]), .o_a(w_l1[2*k]), .o_b(w_l1[2*k+1]));
    end
    for (genvar k = 0; k < 4; k++) begin : g_l2
        dmux2 u_d (.i_in(w_l1[k]), .i_sel(i_sel[0]), .o_a(o_y[2*k]), .o_b(o_y[2*k+1]));
    end
endmodule

// File: rtl/ram8_gates.sv
// ram8_gates: 2:1 mux, 1:2 demux and the single-bit storage cell.
module mux2 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

module dmux2 (
    input  logic i_in,
    input  logic i_sel,
    output logic o_a,
    output logic o_b
);
    assign o_a = i_in & ~i_sel;
    assign o_b = i_in & i_sel;
endmodule

module bit_cell (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    input  logic i_load,
    output logic o_q
);
    logic r_q;
    logic w_d;
    // Hold is a feedback path through the mux, so the flop is clocked every edge.
    mux2 u_fb (.i_a(r_q), .i_b(i_d), .i_sel(i_load), .o_y(w_d));
    always_ff @(posedge clk or posedge reset)
        if (reset) r_q <= 1'b0;
        else       r_q <= w_d;
    assign o_q = r_q;
endmodule

// File: rtl/ram8_mux8way.sv
// mux8way: per-bit 8:1 mux tree; sel[0] at the leaves, sel[2] at the root.
module mux8way
    import ram8_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic [RAM8_DEPTH-1:0][WIDTH-1:0] i_words,
    input  logic [RAM8_ADDR_W-1:0]           i_sel,
    output logic [WIDTH-1:0]                 o_y
);
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [3:0] w_l0;
        logic [1:0] w_l1;
        for (genvar k = 0; k < 4; k++) begin : g_l0
            mux2 u_m (.i_a(i_words[2*k][b]), .i_b(i_words[2*k+1][b]), .i_sel(i_sel[0]), .o_y(w_l0[k]));
        end
        for (genvar k = 0; k < 2; k++) begin : g_l1
            mux2 u_m (.i_a(w_l0[2*k]), .i_b(w_l0[2*k+1]), .i_sel(i_sel[1]), .o_y(w_l1[k]));
        end
        mux2 u_root (.i_a(w_l1[0]), .i_b(w_l1[1]), .i_sel(i_sel[2]), .o_y(o_y[b]));
    end
endmodule

// File: rtl/ram8_register_w.sv
// register_w: WIDTH-bit register with load and async clear, one bit_cell per bit.
module register_w
    import ram8_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_load,
    output logic [WIDTH-1:0] o_q
);
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        bit_cell u_cell (.clk(clk), .reset(reset), .i_d(i_d[b]), .i_load(i_load), .o_q(o_q[b]));
    end
endmodule

// File: rtl/ram8.sv
// ram8: 8-word register file; demux-tree write enables, combinational mux-tree read.
module ram8
    import ram8_pkg::*;
#(
    parameter int WIDTH  = WORD_WIDTH,
    parameter int ADDR_W = RAM8_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out
);
    logic [RAM8_DEPTH-1:0]            w_en;
    logic [RAM8_DEPTH-1:0][WIDTH-1:0] w_words;
    demux8way u_dec (.i_in(load), .i_sel(address), .o_y(w_en));
    for (genvar w = 0; w < RAM8_DEPTH; w++) begin : g_word
        register_w #(.WIDTH(WIDTH)) u_reg (
            .clk(clk), .reset(reset), .i_d(in), .i_load(w_en[w]), .o_q(w_words[w])
        );
    end
    mux8way #(.WIDTH(WIDTH)) u_rd (.i_words(w_words), .i_sel(address), .o_y(out));
endmodule

// File: tb/tb_ram8.sv
// tb_ram8: directed and random checks of ram8 against an array model of the word store.
module tb_ram8;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = '0;
    logic        load = 1'b0;
    logic [2:0]  addr = '0;
    logic [15:0] dout;
    logic [15:0] mem [8];
    int checks = 0;
    int errors = 0;

    ram8 dut (.clk(clk), .reset(reset), .in(din), .load(load), .address(addr), .out(dout));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (dout === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, dout, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        addr = a;
        din  = d;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        mem[a] = d;
    endtask

    task automatic read(input string tag, input logic [2:0] a);
        addr = a;
        #1;
        check(tag, mem[a]);
    endtask

    initial begin
        logic [2:0]  ra;
        logic [15:0] rd;
        logic        rl;
        clear_model();
        #1;
        check("reset_initial", 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        // 1: async reset between edges
        write(3'd3, 16'hBEEF);
        read("pre_reset_a3", 3'd3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_now", 16'h0000);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) read("after_reset_sweep", 3'(a));
        // 2: fill every word, then sweep
        for (int a = 0; a < 8; a++) write(3'(a), 16'h1110 + 16'(a));
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            #1;
            check("fill_sweep", 16'h1110 + 16'(a));
        end
        // 3: read-during-write, old value before the edge, new value after
        write(3'd5, 16'h00AA);
        addr = 3'd5;
        din  = 16'h5555;
        load = 1'b1;
        #1;
        check("rdw_before_edge", 16'h00AA);
        @(posedge clk);
        #1;
        check("rdw_after_edge", 16'h5555);
        load = 1'b0;
        mem[5] = 16'h5555;
        read("rdw_neighbor_a4", 3'd4);
        read("rdw_neighbor_a6", 3'd6);
        // 4: load low holds the word
        write(3'd2, 16'h1234);
        addr = 3'd2;
        din  = 16'hFFFF;
        repeat (4) @(posedge clk);
        #1;
        check("load_low_hold", 16'h1234);
        // 5: reset wins over load on the same edge
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b1;
        din   = 16'hCAFE;
        addr  = 3'd0;
        @(posedge clk);
        #1;
        check("reset_with_load", 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        clear_model();
        read("reset_beats_load_a0", 3'd0);
        // 6: isolation between neighbouring words
        write(3'd7, 16'hFFFF);
        write(3'd6, 16'h0000);
        read("iso_a7", 3'd7);
        read("iso_a6", 3'd6);
        // distinct word per address exposes aliased or swapped decode bits
        for (int a = 0; a < 8; a++) write(3'(a), 16'hA000 | 16'(a * 17));
        for (int a = 0; a < 8; a++) read("alias_sweep", 3'(a));
        // random traffic
        for (int n = 0; n < 300; n++) begin
            ra = 3'($urandom_range(0, 7));
            rd = 16'($urandom);
            rl = 1'($urandom_range(0, 1));
            addr = ra;
            din  = rd;
            load = rl;
            #1;
            check("rand_pre_edge", mem[ra]);
            @(posedge clk);
            #1;
            if (rl) mem[ra] = rd;
            load = 1'b0;
            check("rand_post_edge", mem[ra]);
        end
        for (int a = 0; a < 8; a++) read("final_sweep", 3'(a));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
